// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues synchronous imem reads,
// buffers tagged responses in a small FIFO and feeds decode one registered pair per cycle.
module fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              ISIZE    = 16,
  parameter int              ASIZE    = 16,
  parameter logic [ASIZE-1:0] RESET_PC = '0,
  parameter logic [ISIZE-1:0] NOP      = 16'h7000,
  localparam int             CW       = $clog2(DEPTH + 1),
  localparam int             PW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             Rst,
  output logic             imem_rd_en,
  output logic [ASIZE-1:0] imem_addr,
  input  logic [ISIZE-1:0] imem_data,
  input  logic             stall,
  input  logic             redirect,
  input  logic [ASIZE-1:0] redirect_pc,
  output logic [ISIZE-1:0] instr_out,
  output logic [ASIZE-1:0] pc_out,
  output logic             instr_valid,
  output logic [CW-1:0]    count
);

  typedef struct packed {
    logic [ASIZE-1:0] pc;
    logic [ISIZE-1:0] instr;
  } entry_t;

  logic [ASIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [ASIZE-1:0] tag_q, tag_d;
  logic             inflight_q, inflight_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [ISIZE-1:0] instr_q, instr_d;
  logic [ASIZE-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  entry_t           mem_q [DEPTH];

  logic [CW:0] occ;
  logic        fifo_empty, resp_vld, push, pop, bypass;
  entry_t      head;

  // Occupancy includes the response already in flight so the FIFO can never overflow.
  assign occ        = (CW+1)'(count_q) + (CW+1)'(inflight_q);
  assign imem_rd_en = Rst & ~redirect & (occ < (CW+1)'(DEPTH));
  assign imem_addr  = fetch_pc_q;

  assign fifo_empty = (count_q == '0);
  assign resp_vld   = inflight_q & ~redirect;
  assign pop        = ~redirect & ~stall & ~fifo_empty;
  assign push       = resp_vld & (stall | ~fifo_empty);
  assign bypass     = resp_vld & ~stall & fifo_empty;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    inflight_d = imem_rd_en;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;

    if (imem_rd_en) begin
      fetch_pc_d = fetch_pc_q + ASIZE'(1);
      tag_d      = fetch_pc_q + ASIZE'(1);
    end

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      instr_d    = NOP;
      pc_d       = redirect_pc;
      valid_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (!stall) begin
        if (!fifo_empty) begin
          instr_d = head.instr;
          pc_d    = head.pc;
          valid_d = 1'b1;
        end else if (bypass) begin
          instr_d = imem_data;
          pc_d    = tag_q;
          valid_d = 1'b1;
        end else begin
          instr_d = NOP;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      fetch_pc_q <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      instr_q    <= NOP;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  // Storage needs no reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (Rst && push) mem_q[wr_ptr_q] <= '{pc: tag_q, instr: imem_data};
  end

  assign instr_out   = instr_q;
  assign pc_out      = pc_q;
  assign instr_valid = valid_q;
  assign count       = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table for reset/streaming, hand sequences for
// stall, redirect, wrap and mid-run reset, with a fetch-order scoreboard.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic        imem_rd_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        instr_valid;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_queue dut (
    .clk(clk), .Rst(Rst), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_out(instr_out), .pc_out(pc_out),
    .instr_valid(instr_valid), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    case (a)
      16'h0000: memf = 16'h1234;
      16'h0001: memf = 16'h5678;
      16'h0002: memf = 16'h9ABC;
      16'h0003: memf = 16'hDEF0;
      default:  memf = {a[7:0], ~a[7:0]};
    endcase
  endfunction

  // Synchronous instruction memory: data valid the cycle after the request.
  always @(posedge clk) if (imem_rd_en) imem_data <= memf(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct { logic [15:0] d; logic [15:0] pc; } sb_t;
  sb_t sb[$];
  logic        p_rst = 1'b0, p_stall = 1'b0, p_red = 1'b0, p_rd = 1'b0;
  logic [15:0] p_addr = '0;

  // Each issue pushes its expected pair; every newly produced valid output pops one.
  always @(negedge clk) begin
    sb_t e;
    if (!p_rst || p_red) sb.delete();
    else if (!p_stall && instr_valid) begin
      if (sb.size() == 0) chk("sb_unexpected_valid", {16'h0, instr_out}, 32'hFFFFFFFF);
      else begin
        e = sb.pop_front();
        chk("sb_instr", {16'h0, instr_out}, {16'h0, e.d});
        chk("sb_pc", {16'h0, pc_out}, {16'h0, e.pc});
      end
    end
    if (p_rd) sb.push_back('{d: memf(p_addr), pc: p_addr + 16'd1});
    p_rst = Rst; p_stall = stall; p_red = redirect; p_rd = imem_rd_en; p_addr = imem_addr;
  end

  task automatic cyc(input logic r, input logic s, input logic d, input logic [15:0] rp);
    Rst = r; stall = s; redirect = d; redirect_pc = rp;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic rst, stl, red; logic [15:0] rpc;
    logic e_rd, e_v; logic [15:0] e_i, e_pc; logic [2:0] e_cnt;
  } vec_t;

  initial begin
    vec_t tbl[7];
    logic [15:0] rel_exp[4];
    logic [15:0] wa[3];
    logic [15:0] wp[3];

    tbl[0] = '{1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h7000, 16'h0000, 3'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h7000, 16'h0000, 3'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h7000, 16'h0000, 3'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h1234, 16'h0001, 3'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h5678, 16'h0002, 3'd0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h9ABC, 16'h0003, 3'd0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'hDEF0, 16'h0004, 3'd0};

    for (int i = 0; i < 7; i++) begin
      Rst = tbl[i].rst; stall = tbl[i].stl; redirect = tbl[i].red; redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("tbl%0d_rd_en", i), {31'h0, imem_rd_en}, {31'h0, tbl[i].e_rd});
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_valid", i), {31'h0, instr_valid}, {31'h0, tbl[i].e_v});
      chk($sformatf("tbl%0d_instr", i), {16'h0, instr_out}, {16'h0, tbl[i].e_i});
      chk($sformatf("tbl%0d_pc", i), {16'h0, pc_out}, {16'h0, tbl[i].e_pc});
      chk($sformatf("tbl%0d_count", i), {29'h0, count}, {29'h0, tbl[i].e_cnt});
    end

    // Stall for 6 cycles after the first valid output: FIFO fills, issue stops.
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("stall_first", {16'h0, instr_out}, 32'h1234);
    for (int k = 0; k < 6; k++) begin
      cyc(1, 1, 0, 0);
      chk("stall_hold_instr", {16'h0, instr_out}, 32'h1234);
      chk("stall_hold_valid", {31'h0, instr_valid}, 32'h1);
    end
    chk("stall_full_count", {29'h0, count}, 32'd4);
    chk("stall_full_rd_en", {31'h0, imem_rd_en}, 32'h0);
    rel_exp[0] = 16'h5678; rel_exp[1] = 16'h9ABC; rel_exp[2] = 16'hDEF0; rel_exp[3] = memf(16'h4);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 0);
      chk("release_valid", {31'h0, instr_valid}, 32'h1);
      chk("release_instr", {16'h0, instr_out}, {16'h0, rel_exp[k]});
    end

    // Redirect with 2 queued and 1 in flight.
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    chk("redir_pre_count", {29'h0, count}, 32'd2);
    cyc(1, 0, 1, 16'h0040);
    chk("redir_instr", {16'h0, instr_out}, 32'h7000);
    chk("redir_valid", {31'h0, instr_valid}, 32'h0);
    chk("redir_count", {29'h0, count}, 32'd0);
    chk("redir_pc", {16'h0, pc_out}, 32'h0040);
    Rst = 1; stall = 0; redirect = 0; #1;
    chk("redir_addr", {16'h0, imem_addr}, 32'h0040);
    chk("redir_rd_en", {31'h0, imem_rd_en}, 32'h1);
    @(posedge clk); #1;
    chk("redir_gap_valid", {31'h0, instr_valid}, 32'h0);
    cyc(1, 0, 0, 0);
    chk("redir_tgt_valid", {31'h0, instr_valid}, 32'h1);
    chk("redir_tgt_instr", {16'h0, instr_out}, {16'h0, memf(16'h0040)});
    chk("redir_tgt_pc", {16'h0, pc_out}, 32'h0041);

    // Redirect and stall together: redirect wins, output holds NOP while refilling.
    cyc(1, 1, 1, 16'h0080);
    chk("rs_instr", {16'h0, instr_out}, 32'h7000);
    chk("rs_count", {29'h0, count}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 0, 0);
      chk("rs_hold_instr", {16'h0, instr_out}, 32'h7000);
      chk("rs_hold_valid", {31'h0, instr_valid}, 32'h0);
    end
    chk("rs_refill_count", {29'h0, count}, 32'd2);
    cyc(1, 0, 0, 0);
    chk("rs_out_instr", {16'h0, instr_out}, {16'h0, memf(16'h0080)});
    chk("rs_out_pc", {16'h0, pc_out}, 32'h0081);

    // Fetch PC wrap.
    cyc(1, 0, 1, 16'hFFFE);
    wa[0] = 16'hFFFE; wa[1] = 16'hFFFF; wa[2] = 16'h0000;
    wp[0] = 16'h0000; wp[1] = 16'hFFFF; wp[2] = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      Rst = 1; stall = 0; redirect = 0; #1;
      chk("wrap_addr", {16'h0, imem_addr}, {16'h0, wa[k]});
      @(posedge clk); #1;
      if (k > 0) chk("wrap_pc", {16'h0, pc_out}, {16'h0, wp[k]});
    end
    cyc(1, 0, 0, 0);
    chk("wrap_pc_last", {16'h0, pc_out}, 32'h0001);

    // Reset pulse with 3 entries queued.
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    chk("mrst_pre_count", {29'h0, count}, 32'd3);
    cyc(0, 1, 0, 0);
    chk("mrst_count", {29'h0, count}, 32'd0);
    chk("mrst_valid", {31'h0, instr_valid}, 32'h0);
    chk("mrst_instr", {16'h0, instr_out}, 32'h7000);
    Rst = 1; stall = 0; redirect = 0; #1;
    chk("mrst_addr", {16'h0, imem_addr}, 32'h0000);
    @(posedge clk); #1;
    chk("mrst_gap_valid", {31'h0, instr_valid}, 32'h0);
    cyc(1, 0, 0, 0);
    chk("mrst_first_instr", {16'h0, instr_out}, 32'h1234);
    chk("mrst_first_pc", {16'h0, pc_out}, 32'h0001);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the decode stage.
- Owns the fetch PC and issues reads to the synchronous instruction memory.
- Buffers returned instructions, tagged with PC+1, in a small FIFO so fetch runs ahead while decode is stalled.
- Presents one registered instruction/PC pair per cycle to decode; flushes on branch/jump redirect and supplies NOP (16'h7000) when it has nothing valid.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, >=2)
- ISIZE, 16, instruction width
- ASIZE, 16, PC/address width
- RESET_PC, 16'h0000, fetch PC after reset
- NOP, 16'h7000, instruction driven when output is not valid

Ports:
- clk  in  1  clock; all state updates on posedge
- Rst  in  1  reset, synchronous, active-low
- imem_rd_en  out  1  read request to instruction memory this cycle
- imem_addr  out  ASIZE  read address (= fetch_pc)
- imem_data  in  ISIZE  read data, valid the cycle after imem_rd_en
- stall  in  1  decode cannot accept; hold output registers
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  ASIZE  new fetch PC when redirect=1
- instr_out  out  ISIZE  registered instruction to decode
- pc_out  out  ASIZE  registered PC+1 of instr_out
- instr_valid  out  1  instr_out is a real fetched instruction
- count  out  clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on Rst. While Rst=0 at a posedge:
  - fetch_pc=RESET_PC, FIFO empty (count=0), in-flight flag cleared.
  - instr_out=NOP, pc_out=0, instr_valid=0.
  - imem_rd_en is forced to 0 combinationally while Rst=0.
- Issue (combinational): imem_rd_en = Rst & ~redirect & (count + inflight < DEPTH); imem_addr = fetch_pc.
  - On an issuing edge: fetch_pc <= fetch_pc+1 (mod 2^ASIZE, wraps FFFF->0000) and inflight <= 1; otherwise inflight <= 0.
- Response: the cycle after an issue, imem_data is accepted with tag (issued PC)+1, unless a redirect occurred in the issue cycle or the response cycle; in that case the response is killed.
- Output update at each posedge, in priority order:
  1. Reset.
  2. redirect=1:
     - instr_out<=NOP, instr_valid<=0, pc_out<=redirect_pc.
     - FIFO cleared, in-flight response killed, fetch_pc<=redirect_pc.
     - Overrides stall.
  3. stall=1: output registers hold. A response still pushes into the FIFO; the FIFO never overflows because of the issue guard.
  4. Not stalled, FIFO non-empty: pop head to instr_out/pc_out, instr_valid<=1. A simultaneous response push is allowed; count is unchanged.
  5. Not stalled, FIFO empty, response arriving: bypass the response straight to the outputs, instr_valid<=1, no push.
  6. Otherwise: instr_out<=NOP, instr_valid<=0, pc_out holds.
- Latency: first issue in cycle N (first cycle with Rst=1); instr_out valid in cycle N+2. Steady state is 1 instruction/cycle.
- FIFO implementation: circular buffer with read/write pointers modulo DEPTH. Full when count=DEPTH; issue is already blocked when count+inflight=DEPTH.
- Reset mid-operation: all state is discarded, including the in-flight response. The first post-reset fetch is RESET_PC.
- Ordering: instructions leave in strict fetch order. The FIFO has no reorder capability.

Test Plan:
- Reset, then imem[0..3]=1234,5678,9ABC,DEF0, stall=0 -> cycles N+2..N+5 give instr_out=1234,5678,9ABC,DEF0 with pc_out=1,2,3,4 and instr_valid=1; during reset instr_out=7000 and valid=0.
- Hold stall=1 for 6 cycles after the first valid -> instr_out held at 1234; count rises to 4 (DEPTH) and imem_rd_en drops to 0. On release, the next 4 outputs are 5678,9ABC,DEF0,imem[4] back-to-back with no bubble.
- Redirect to 0x0040 with 2 queued plus 1 in flight -> next edge instr_out=7000, valid=0, count=0; imem_addr=0x0040 the following cycle; the first valid output is imem[0x40] with pc_out=0x41, 2 cycles later; no stale instruction appears.
- redirect=1 and stall=1 in the same cycle -> redirect wins: flush and NOP. With stall still high afterwards, the output holds NOP while the FIFO refills from redirect_pc.
- fetch_pc=0xFFFE, streaming -> addresses FFFE, FFFF, 0000 are issued; pc_out=FFFF, 0000, 0001.
- Rst pulsed low for 1 cycle while 3 entries are queued -> count=0, valid=0; after release, fetch restarts at RESET_PC and no pre-reset instruction emerges.
